// File: rtl/reqack_responder_fifo.sv
// Responder end of the req/ack pull handshake: a valid/ready stream fills a
// DEPTH-entry FIFO, and each accepted req is answered with a one-cycle ack plus a registered data word.
module reqack_responder_fifo #(
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 4,
  parameter int unsigned addr_width = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [data_width-1:0] s_data,
  input  logic                  req,
  output logic                  ack,
  output logic [data_width-1:0] dout,
  output logic [addr_width:0]   level,
  output logic [31:0]           count
);

  logic [data_width-1:0] mem_q [depth];
  logic [addr_width:0]   wr_ptr_q, wr_ptr_d;
  logic [addr_width:0]   rd_ptr_q, rd_ptr_d;
  logic                  ack_q, ack_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic [31:0]           count_q, count_d;
  logic                  full, empty, push, pull;

  always_comb begin
    full  = (wr_ptr_q[addr_width] != rd_ptr_q[addr_width]) &&
            (wr_ptr_q[addr_width-1:0] == rd_ptr_q[addr_width-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
    push  = s_valid & ~full;
    // The ~ack_q guard stops a second ack on the edge where the initiator drops req.
    pull  = req & ~ack_q & ~empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ack_d    = 1'b0;
    dout_d   = dout_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + {{addr_width{1'b0}}, 1'b1};
    end
    if (pull) begin
      ack_d    = 1'b1;
      dout_d   = mem_q[rd_ptr_q[addr_width-1:0]];
      rd_ptr_d = rd_ptr_q + {{addr_width{1'b0}}, 1'b1};
      count_d  = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ack_q    <= 1'b0;
      dout_q   <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ack_q    <= ack_d;
      dout_q   <= dout_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q[addr_width-1:0]] <= s_data;
    end
  end

  assign s_ready = ~full;
  assign ack     = ack_q;
  assign dout    = dout_q;
  assign level   = wr_ptr_q - rd_ptr_q;
  assign count   = count_q;

endmodule
